// File: rtl/test_seq_ctrl.sv
// -----------------------------------------------------------------------------
// test_seq_ctrl
//
// Launches up to NUM_TESTS self-checking sub-blocks one after another and
// collects their pass/fail results. Each launched test receives a one-cycle
// start pulse. The sequencer then waits for that test's done/pass pair,
// optionally bounded by a per-test watchdog. A run can be shaped by an enable
// mask, a starting index, a quota of completed tests, stop-on-fail, and an
// asynchronous-intent abort request (sampled synchronously).
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   go                       start-run pulse, ignored while busy
//   test_mask                per-test enable, latched on an accepted go
//   first_test               starting index, latched on go
//   max_tests                completed-test quota (0 = unlimited), latched on go
//   timeout_cycles           WAIT-cycle budget per test (0 = none), latched on go
//   stop_on_fail             end the run at the first failure, latched on go
//   abort                    ends an active run; no effect when idle/finishing
//   start_o                  one-hot, one-cycle start pulse to the current test
//   done_i / pass_i          per-test done strobe and qualified pass flag
//   busy                     run in progress
//   suite_done               one-cycle pulse in the final cycle of a run
//   aborted                  last run was ended by abort
//   curr_test                index currently being examined
//   pass_vec/fail_vec/timeout_vec   per-test results of the last run
//   passed_cnt/failed_cnt/completed_cnt   summary counters of the last run
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module test_seq_ctrl #(
  parameter int NUM_TESTS = 7,
  parameter int IDX_W     = $clog2(NUM_TESTS) + 1,
  parameter int TIMEOUT_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [NUM_TESTS-1:0] test_mask,
  input  logic [IDX_W-1:0]     first_test,
  input  logic [IDX_W-1:0]     max_tests,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 stop_on_fail,
  input  logic                 abort,
  output logic [NUM_TESTS-1:0] start_o,
  input  logic [NUM_TESTS-1:0] done_i,
  input  logic [NUM_TESTS-1:0] pass_i,
  output logic                 busy,
  output logic                 suite_done,
  output logic                 aborted,
  output logic [IDX_W-1:0]     curr_test,
  output logic [NUM_TESTS-1:0] pass_vec,
  output logic [NUM_TESTS-1:0] fail_vec,
  output logic [NUM_TESTS-1:0] timeout_vec,
  output logic [IDX_W-1:0]     passed_cnt,
  output logic [IDX_W-1:0]     failed_cnt,
  output logic [IDX_W-1:0]     completed_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } state_t;

  localparam logic [NUM_TESTS-1:0] VEC_ONE = NUM_TESTS'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0]     IDX_NT  = IDX_W'(NUM_TESTS);
  localparam logic [TIMEOUT_W-1:0] TMO_ONE = TIMEOUT_W'(1);

  // One-hot select for an index; indices at or beyond NUM_TESTS select
  // nothing, so out-of-range indices never reach the per-test vectors.
  function automatic logic [NUM_TESTS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    idx_onehot = VEC_ONE << idx;
  endfunction

  // Counter increment. The counters are bounded by NUM_TESTS and IDX_W has
  // one spare bit, so a plain increment cannot wrap.
  function automatic logic [IDX_W-1:0] cnt_inc(input logic [IDX_W-1:0] c);
    cnt_inc = c + IDX_ONE;
  endfunction

  state_t               state_q;

  // Configuration captured on an accepted go.
  logic [NUM_TESTS-1:0] mask_q;
  logic [IDX_W-1:0]     max_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 sof_q;

  logic [TIMEOUT_W-1:0] timer_q;
  logic [IDX_W-1:0]     curr_q;
  logic [NUM_TESTS-1:0] start_q;
  logic                 busy_q;
  logic                 sdone_q;
  logic                 aborted_q;
  logic [NUM_TESTS-1:0] pass_q;
  logic [NUM_TESTS-1:0] fail_q;
  logic [NUM_TESTS-1:0] tmov_q;
  logic [IDX_W-1:0]     pcnt_q;
  logic [IDX_W-1:0]     fcnt_q;
  logic [IDX_W-1:0]     ccnt_q;

  logic [NUM_TESTS-1:0] sel_oh;
  logic [IDX_W-1:0]     curr_d;
  logic                 in_range;
  logic                 quota_hit;
  logic                 sel_en;
  logic                 sel_done;
  logic                 sel_pass;
  logic                 tmo_hit;

  // Everything about "the current test" is derived through sel_oh, which
  // also makes done_i/pass_i bits of other tests invisible to the FSM.
  assign sel_oh    = idx_onehot(curr_q);
  assign curr_d    = cnt_inc(curr_q);
  assign in_range  = (curr_q < IDX_NT);
  assign quota_hit = (max_q != '0) && (ccnt_q == max_q);
  assign sel_en    = |(mask_q & sel_oh);
  assign sel_done  = |(done_i & sel_oh);
  assign sel_pass  = |(pass_i & sel_oh);
  // The timer counts WAIT cycles from 0, so matching budget-1 means this is
  // the last cycle the test is granted.
  assign tmo_hit   = (tmo_q != '0) && (timer_q == (tmo_q - TMO_ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      max_q     <= '0;
      tmo_q     <= '0;
      sof_q     <= 1'b0;
      timer_q   <= '0;
      curr_q    <= '0;
      start_q   <= '0;
      busy_q    <= 1'b0;
      sdone_q   <= 1'b0;
      aborted_q <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
      tmov_q    <= '0;
      pcnt_q    <= '0;
      fcnt_q    <= '0;
      ccnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          start_q <= '0;
          sdone_q <= 1'b0;
          if (go) begin
            mask_q    <= test_mask;
            max_q     <= max_tests;
            tmo_q     <= timeout_cycles;
            sof_q     <= stop_on_fail;
            curr_q    <= first_test;
            aborted_q <= 1'b0;
            pass_q    <= '0;
            fail_q    <= '0;
            tmov_q    <= '0;
            pcnt_q    <= '0;
            fcnt_q    <= '0;
            ccnt_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_SEEK;
          end
        end

        S_SEEK: begin
          if (abort) begin
            aborted_q <= 1'b1;
            sdone_q   <= 1'b1;
            state_q   <= S_FINISH;
          end else if (!in_range || quota_hit) begin
            sdone_q <= 1'b1;
            state_q <= S_FINISH;
          end else if (sel_en) begin
            // Raised here so the pulse is registered and lines up with LAUNCH.
            start_q <= sel_oh;
            state_q <= S_LAUNCH;
          end else begin
            curr_q <= curr_d;
          end
        end

        S_LAUNCH: begin
          // done_i is deliberately not looked at in this cycle.
          start_q <= '0;
          timer_q <= '0;
          if (abort) begin
            aborted_q <= 1'b1;
            sdone_q   <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            // The in-flight test is dropped without touching any result.
            aborted_q <= 1'b1;
            sdone_q   <= 1'b1;
            state_q   <= S_FINISH;
          end else if (sel_done || tmo_hit) begin
            ccnt_q <= cnt_inc(ccnt_q);
            // A done in the same cycle as the watchdog expiry takes priority.
            if (sel_done && sel_pass) begin
              pass_q  <= pass_q | sel_oh;
              pcnt_q  <= cnt_inc(pcnt_q);
              curr_q  <= curr_d;
              state_q <= S_SEEK;
            end else begin
              fail_q <= fail_q | sel_oh;
              fcnt_q <= cnt_inc(fcnt_q);
              if (!sel_done) begin
                tmov_q <= tmov_q | sel_oh;
              end
              if (sof_q) begin
                sdone_q <= 1'b1;
                state_q <= S_FINISH;
              end else begin
                curr_q  <= curr_d;
                state_q <= S_SEEK;
              end
            end
          end else begin
            timer_q <= timer_q + TMO_ONE;
          end
        end

        S_FINISH: begin
          // go and abort are both ignored here; results hold until next go.
          sdone_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          start_q <= '0;
          sdone_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign start_o       = start_q;
  assign busy          = busy_q;
  assign suite_done    = sdone_q;
  assign aborted       = aborted_q;
  assign curr_test     = curr_q;
  assign pass_vec      = pass_q;
  assign fail_vec      = fail_q;
  assign timeout_vec   = tmov_q;
  assign passed_cnt    = pcnt_q;
  assign failed_cnt    = fcnt_q;
  assign completed_cnt = ccnt_q;

endmodule

// File: tb/tb_test_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for test_seq_ctrl. A responder models the sub-blocks (configurable
// latency, pass flag, or silence). Expected launch order and expected end-of-
// run results are queued when a run is set up and checked as the DUT emits
// start pulses and suite_done.
// -----------------------------------------------------------------------------
module tb_test_seq_ctrl;

  localparam int NT = 7;
  localparam int IW = 4;
  localparam int TW = 20;

  logic          clk;
  logic          rst;
  logic          go;
  logic [NT-1:0] test_mask;
  logic [IW-1:0] first_test;
  logic [IW-1:0] max_tests;
  logic [TW-1:0] timeout_cycles;
  logic          stop_on_fail;
  logic          abort;
  logic [NT-1:0] start_o;
  logic [NT-1:0] done_i;
  logic [NT-1:0] pass_i;
  logic          busy;
  logic          suite_done;
  logic          aborted;
  logic [IW-1:0] curr_test;
  logic [NT-1:0] pass_vec;
  logic [NT-1:0] fail_vec;
  logic [NT-1:0] timeout_vec;
  logic [IW-1:0] passed_cnt;
  logic [IW-1:0] failed_cnt;
  logic [IW-1:0] completed_cnt;

  logic [NT-1:0] resp_done;
  logic [NT-1:0] resp_pass;
  logic [NT-1:0] spur_done;
  logic [NT-1:0] spur_pass;

  assign done_i = resp_done | spur_done;
  assign pass_i = resp_pass | spur_pass;

  typedef struct {
    logic [NT-1:0] pv;
    logic [NT-1:0] fv;
    logic [NT-1:0] tv;
    logic [IW-1:0] p;
    logic [IW-1:0] f;
    logic [IW-1:0] c;
    logic          ab;
  } res_t;

  res_t res_q[$];
  int   start_q[$];

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;
  int start_cyc[NT];
  int go_cyc;
  int sd_cyc;

  // Responder configuration.
  logic [NT-1:0] cfg_en;
  logic [NT-1:0] cfg_pass;
  int            cfg_dly[NT];

  logic          act_on;
  logic [2:0]    act_idx;
  int            act_cnt;

  test_seq_ctrl #(.NUM_TESTS(NT), .IDX_W(IW), .TIMEOUT_W(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .go             (go),
    .test_mask      (test_mask),
    .first_test     (first_test),
    .max_tests      (max_tests),
    .timeout_cycles (timeout_cycles),
    .stop_on_fail   (stop_on_fail),
    .abort          (abort),
    .start_o        (start_o),
    .done_i         (done_i),
    .pass_i         (pass_i),
    .busy           (busy),
    .suite_done     (suite_done),
    .aborted        (aborted),
    .curr_test      (curr_test),
    .pass_vec       (pass_vec),
    .fail_vec       (fail_vec),
    .timeout_vec    (timeout_vec),
    .passed_cnt     (passed_cnt),
    .failed_cnt     (failed_cnt),
    .completed_cnt  (completed_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_res(input logic [NT-1:0] pv, input logic [NT-1:0] fv,
                          input logic [NT-1:0] tv, input logic [IW-1:0] p,
                          input logic [IW-1:0] f, input logic [IW-1:0] c,
                          input logic ab);
    res_t r;
    r.pv = pv; r.fv = fv; r.tv = tv; r.p = p; r.f = f; r.c = c; r.ab = ab;
    res_q.push_back(r);
  endtask

  task automatic run_go(input logic [NT-1:0] m, input logic [IW-1:0] first,
                        input logic [IW-1:0] mx, input logic [TW-1:0] tmo,
                        input logic sof);
    test_mask      = m;
    first_test     = first;
    max_tests      = mx;
    timeout_cycles = tmo;
    stop_on_fail   = sof;
    go             = 1'b1;
    go_cyc         = cyc;
    tick();
    go             = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (suite_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    sd_cyc = cyc;
    compared++;
    assert (found) else begin
      mism++;
      $error("FAIL %s: observed no suite_done within %0d cycles, expected suite_done", tag, budget);
    end
  endtask

  task automatic wait_start(input string tag, input int t, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (start_o[t] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    compared++;
    assert (found) else begin
      mism++;
      $error("FAIL %s: observed no start_o[%0d] within %0d cycles, expected a start", tag, t, budget);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".start_o"},     32'(start_o),       32'h0);
    chk({tag, ".busy"},        32'(busy),          32'h0);
    chk({tag, ".suite_done"},  32'(suite_done),    32'h0);
    chk({tag, ".aborted"},     32'(aborted),       32'h0);
    chk({tag, ".curr_test"},   32'(curr_test),     32'h0);
    chk({tag, ".pass_vec"},    32'(pass_vec),      32'h0);
    chk({tag, ".fail_vec"},    32'(fail_vec),      32'h0);
    chk({tag, ".timeout_vec"}, 32'(timeout_vec),   32'h0);
    chk({tag, ".passed"},      32'(passed_cnt),    32'h0);
    chk({tag, ".failed"},      32'(failed_cnt),    32'h0);
    chk({tag, ".completed"},   32'(completed_cnt), 32'h0);
  endtask

  // Responder and scoreboard consumer, both mid-cycle.
  always @(negedge clk) begin
    logic [2:0] t;
    int         e;
    res_t       r;
    resp_done = '0;
    resp_pass = '0;
    if (rst) begin
      act_on = 1'b0;
    end else begin
      if (act_on) begin
        act_cnt--;
        if (act_cnt <= 0) begin
          resp_done[act_idx] = 1'b1;
          resp_pass[act_idx] = cfg_pass[act_idx];
          act_on = 1'b0;
        end
      end
      if (start_o != '0) begin
        t = 3'd0;
        for (int i = NT - 1; i >= 0; i--) if (start_o[i]) t = 3'(i);
        start_cyc[t] = cyc;
        compared++;
        assert (start_q.size() != 0) else begin
          mism++;
          $error("FAIL start_unexp: observed start_o=0x%0h, expected no start", start_o);
        end
        if (start_q.size() != 0) begin
          e = start_q.pop_front();
          chk("start_o", 32'(start_o), 32'(1) << e);
        end
        if (cfg_en[t]) begin
          act_on  = 1'b1;
          act_idx = t;
          act_cnt = cfg_dly[t];
        end
      end
      if (suite_done === 1'b1) begin
        compared++;
        assert (res_q.size() != 0) else begin
          mism++;
          $error("FAIL sdone_unexp: observed suite_done=1, expected 0");
        end
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          chk("res.pass_vec",    32'(pass_vec),      32'(r.pv));
          chk("res.fail_vec",    32'(fail_vec),      32'(r.fv));
          chk("res.timeout_vec", 32'(timeout_vec),   32'(r.tv));
          chk("res.passed",      32'(passed_cnt),    32'(r.p));
          chk("res.failed",      32'(failed_cnt),    32'(r.f));
          chk("res.completed",   32'(completed_cnt), 32'(r.c));
          chk("res.aborted",     32'(aborted),       32'(r.ab));
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    go             = 1'b0;
    abort          = 1'b0;
    test_mask      = '0;
    first_test     = '0;
    max_tests      = '0;
    timeout_cycles = '0;
    stop_on_fail   = 1'b0;
    spur_done      = '0;
    spur_pass      = '0;
    cfg_en         = '1;
    cfg_pass       = '1;
    for (int i = 0; i < NT; i++) cfg_dly[i] = 5;

    // Reset state.
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Full walk, tests 2 and 5 fail; spurious done and go while busy.
    cfg_pass = 7'b1011011;
    for (int i = 0; i < NT; i++) start_q.push_back(i);
    push_res(7'h5B, 7'h24, 7'h00, 4'd5, 4'd2, 4'd7, 1'b0);
    run_go(7'h7F, 4'd0, 4'd0, 20'd0, 1'b0);
    chk("walk.busy_c1", 32'(busy), 32'h1);
    chk("walk.start_c1", 32'(start_o), 32'h0);
    tick();
    chk("walk.start_c2", 32'(start_o), 32'h01);
    tick();
    spur_done = 7'h10;
    spur_pass = 7'h00;
    tick();
    spur_done = '0;
    go         = 1'b1;
    first_test = 4'd3;
    test_mask  = 7'h00;
    tick();
    go         = 1'b0;
    wait_done("walk.done", 200);
    chk("walk.busy_fin", 32'(busy), 32'h1);
    chk("walk.lat0", 32'(start_cyc[0] - go_cyc), 32'd2);
    chk("walk.gap01", 32'(start_cyc[1] - start_cyc[0]), 32'd7);
    chk("walk.gap56", 32'(start_cyc[6] - start_cyc[5]), 32'd7);
    tick();
    chk("walk.busy_idle", 32'(busy), 32'h0);
    chk("walk.sdone_fall", 32'(suite_done), 32'h0);
    chk("walk.starts_left", 32'(start_q.size()), 32'd0);

    // Quota of one test.
    cfg_pass = '1;
    for (int i = 0; i < NT; i++) cfg_dly[i] = 4;
    start_q.push_back(1);
    push_res(7'h02, 7'h00, 7'h00, 4'd1, 4'd0, 4'd1, 1'b0);
    run_go(7'h12, 4'd0, 4'd1, 20'd0, 1'b0);
    wait_done("quota.done", 200);
    tick();
    chk("quota.starts_left", 32'(start_q.size()), 32'd0);

    // Silent test 3 with a 10-cycle watchdog.
    cfg_en[3] = 1'b0;
    start_q.push_back(3);
    push_res(7'h00, 7'h08, 7'h08, 4'd0, 4'd1, 4'd1, 1'b0);
    run_go(7'h08, 4'd0, 4'd0, 20'd10, 1'b1);
    wait_done("tmo.done", 200);
    chk("tmo.latency", 32'(sd_cyc - start_cyc[3]), 32'd11);
    tick();

    // Done on the 10th WAIT cycle beats the watchdog.
    cfg_en[3]  = 1'b1;
    cfg_dly[3] = 10;
    start_q.push_back(3);
    push_res(7'h08, 7'h00, 7'h00, 4'd1, 4'd0, 4'd1, 1'b0);
    run_go(7'h08, 4'd0, 4'd0, 20'd10, 1'b1);
    wait_done("tmo_edge.done", 200);
    tick();

    // Stop on first failure.
    for (int i = 0; i < NT; i++) cfg_dly[i] = 3;
    cfg_pass = 7'b1111101;
    start_q.push_back(0);
    start_q.push_back(1);
    push_res(7'h01, 7'h02, 7'h00, 4'd1, 4'd1, 4'd2, 1'b0);
    run_go(7'h7F, 4'd0, 4'd0, 20'd0, 1'b1);
    wait_done("sof.done", 200);
    chk("sof.latency", 32'(sd_cyc - start_cyc[1]), 32'd4);
    tick();
    chk("sof.starts_left", 32'(start_q.size()), 32'd0);

    // Abort while idle does nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("idle_abort.aborted", 32'(aborted), 32'h0);
    chk("idle_abort.busy", 32'(busy), 32'h0);
    chk("idle_abort.completed", 32'(completed_cnt), 32'd2);

    // Abort three cycles into test 2's WAIT.
    cfg_pass   = '1;
    cfg_dly[2] = 20;
    start_q.push_back(0);
    start_q.push_back(1);
    start_q.push_back(2);
    push_res(7'h03, 7'h00, 7'h00, 4'd2, 4'd0, 4'd2, 1'b1);
    run_go(7'h7F, 4'd0, 4'd0, 20'd0, 1'b0);
    wait_start("abort.start2", 2, 100);
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.sdone", 32'(suite_done), 32'h1);
    chk("abort.aborted", 32'(aborted), 32'h1);
    chk("abort.completed", 32'(completed_cnt), 32'd2);
    tick();
    chk("abort.busy_idle", 32'(busy), 32'h0);

    // first_test past the end: immediate finish; go in FINISH ignored.
    push_res(7'h00, 7'h00, 7'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    run_go(7'h7F, 4'd7, 4'd0, 20'd0, 1'b0);
    tick();
    chk("first7.sdone", 32'(suite_done), 32'h1);
    chk("first7.curr", 32'(curr_test), 32'd7);
    chk("first7.busy", 32'(busy), 32'h1);
    go         = 1'b1;
    first_test = 4'd0;
    tick();
    go = 1'b0;
    chk("fin_go.busy", 32'(busy), 32'h0);
    tick();
    tick();
    chk("fin_go.busy_later", 32'(busy), 32'h0);
    chk("fin_go.starts_left", 32'(start_q.size()), 32'd0);

    // Reset in the middle of a run.
    for (int i = 0; i < NT; i++) cfg_dly[i] = 5;
    cfg_dly[0] = 2;
    cfg_dly[1] = 30;
    start_q.push_back(0);
    start_q.push_back(1);
    run_go(7'h7F, 4'd0, 4'd0, 20'd0, 1'b0);
    wait_start("rst.start1", 1, 100);
    tick();
    tick();
    chk("rst.pre_pass_vec", 32'(pass_vec), 32'h01);
    chk("rst.pre_passed", 32'(passed_cnt), 32'd1);
    chk("rst.pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrst");
    tick();
    chk("midrst.busy_after", 32'(busy), 32'h0);
    chk("midrst.sdone_after", 32'(suite_done), 32'h0);
    chk("end.starts_left", 32'(start_q.size()), 32'd0);
    chk("end.results_left", 32'(res_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/test_seq_ctrl.md
# test_seq_ctrl

Synthesizable, parametrised test sequencer that launches up to NUM_TESTS self-checking sub-blocks one at a time and collects their pass/fail results. Each sub-block gets a one-cycle start pulse, and the sequencer waits for its done/pass pair, with an optional per-test timeout watchdog. It supports a run mask, a start index, a run quota, stop-on-fail and abort. It sits between a control register bank (or bench driver) and the per-test start/done handshakes, and exposes per-test result vectors and summary counters.

## Interface
Parameters:
- NUM_TESTS, 7, number of test channels (≥1)
- IDX_W, $clog2(NUM_TESTS)+1, width of index/counter ports (one extra bit so NUM_TESTS is representable)
- TIMEOUT_W, 20, width of timeout counter

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- go  in  1  start-run pulse; ignored while busy
- test_mask  in  NUM_TESTS  enabled tests; sampled on accepted go
- first_test  in  IDX_W  starting index; sampled on go
- max_tests  in  IDX_W  run quota, 0 = unlimited; sampled on go
- timeout_cycles  in  TIMEOUT_W  WAIT-cycle budget per test, 0 = disabled; sampled on go
- stop_on_fail  in  1  end run at first failure; sampled on go
- abort  in  1  level/pulse; ends an active run
- start_o  out  NUM_TESTS  one-hot, one-cycle start pulse to the current test
- done_i  in  NUM_TESTS  per-test done strobes
- pass_i  in  NUM_TESTS  per-test pass flag, qualified by done_i of same bit
- busy  out  1  run in progress
- suite_done  out  1  one-cycle pulse at end of run
- aborted  out  1  last run ended by abort
- curr_test  out  IDX_W  index under examination
- pass_vec, fail_vec, timeout_vec  out  NUM_TESTS  per-test results of last run
- passed_cnt, failed_cnt, completed_cnt  out  IDX_W  summary counters

## Operation
- FSM states: IDLE, SEEK, LAUNCH, WAIT, FINISH.
- IDLE: busy=0.
  - On go: latch the configuration, clear all vectors, counters and aborted, set curr_test=first_test, go to SEEK.
- SEEK:
  - If curr_test ≥ NUM_TESTS, or max_tests≠0 and completed_cnt==max_tests: go to FINISH.
  - Else if mask bit set: go to LAUNCH.
  - Else curr_test+1 and stay in SEEK; each masked test costs one cycle.
- LAUNCH: start_o[curr_test]=1 for this cycle only; clear timer; go to WAIT.
- WAIT: timer increments each cycle.
  - If done_i[curr_test]:
    - pass_i[curr_test]=1: set pass_vec bit, passed_cnt+1.
    - Otherwise: set fail_vec bit, failed_cnt+1.
    - In both cases completed_cnt+1.
    - If failed and stop_on_fail: go to FINISH. Else curr_test+1 and go to SEEK.
  - Else if timeout_cycles≠0 and timer==timeout_cycles-1: treat as a failure and also set the timeout_vec bit. Stop-on-fail rules apply.
- FINISH: suite_done=1 for one cycle; go to IDLE. Results hold until the next accepted go.
- done_i/pass_i bits of non-current tests are ignored at all times.
- done_i[curr_test] during the LAUNCH cycle is ignored.
- done and timeout in the same cycle: done wins, and its pass_i value is recorded.
- abort in SEEK/LAUNCH/WAIT: go to FINISH next cycle and set aborted=1. The in-flight test is not recorded and counters are unchanged. abort in IDLE or FINISH has no effect.
- go while busy, including in FINISH: ignored.
- Counters cannot overflow: they are bounded by NUM_TESTS and IDX_W covers it.

## Timing
- Reset: FSM=IDLE. All outputs 0: start_o, busy, suite_done, aborted, curr_test, all vectors and counters.
- rst mid-run: everything returns to reset values next cycle, with no suite_done pulse.
- go accepted at cycle 0 → busy=1 from cycle 1 (SEEK).
- If first_test is enabled, start_o is asserted at cycle 2.
- Result vectors and counters update at the clock edge that samples done_i, and are visible the next cycle.
- Next start_o comes 2 cycles after the done cycle, plus 1 per skipped masked test.
- With a timeout, a test gets exactly timeout_cycles WAIT cycles. The timeout is recorded at the edge ending the last of them.
- suite_done is asserted in the FINISH cycle. busy deasserts in the same cycle suite_done falls.
- All outputs are registered.

## Test plan
- NUM_TESTS=7, mask=7'h7F, first=0, max=0, no timeout; each test returns done 5 cycles after start, tests 2 and 5 fail → start_o walks bits 0..6 one at a time; fail_vec=7'h24, pass_vec=7'h5B, passed=5, failed=2, completed=7, one suite_done pulse.
- mask=7'h12, first=0, max=1 → only start_o[1] fires; completed=1; test 4 never started.
- timeout_cycles=10, test 3 never responds, mask=7'h08 → timeout_vec=7'h08, fail_vec=7'h08, failed=1; suite_done arrives 10 WAIT cycles after start_o[3]. Repeat with done at the 10th WAIT cycle → recorded as pass.
- stop_on_fail=1, test 1 fails, mask=7'h7F → tests 2..6 never started; completed=2, suite_done follows.
- abort 3 cycles into test 2's WAIT → aborted=1, completed=2, no bits set for test 2. Then rst mid-run → all outputs zero next cycle.
- Spurious done_i[4] while test 0 is running, go pulsed while busy, first_test=7 → no effect, no effect, and an immediate suite_done with all counters zero, respectively.
